// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH/EXEC control for the PC datapath,
// branch/jump decisions and a small CALL/RET return-address stack.
module pc_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int STACK_DEPTH = 4,
    localparam int IDX_W      = $clog2(STACK_DEPTH),
    localparam int SP_W       = IDX_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [2:0]        br_type_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              zero_i,
    input  logic [ADDR_W-1:0] pc_in_i,
    output logic              ir_load_o,
    output logic              pc_step_o,
    output logic              jmp_o,
    output logic [ADDR_W-1:0] jmpAdrs_o,
    output logic              halted_o,
    output logic              stack_err_o,
    output logic [SP_W-1:0]   sp_o
);

    // state  | meaning
    // IDLE   | stopped, waiting for run
    // FETCH  | instruction register loads
    // EXEC   | PC advances or jumps, stack push/pop
    // HALTED | HALT executed, waits for run to drop
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [2:0] BR_JMP  = 3'd1;
    localparam logic [2:0] BR_JZ   = 3'd2;
    localparam logic [2:0] BR_JNZ  = 3'd3;
    localparam logic [2:0] BR_CALL = 3'd4;
    localparam logic [2:0] BR_RET  = 3'd5;
    localparam logic [2:0] BR_HALT = 3'd6;

    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [1:0]        state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic              push;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_m1;
    logic [ADDR_W-1:0] ret_addr;

    assign sp_m1    = sp_q - SP_W'(1);
    assign ret_addr = pc_in_i + ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        err_d     = err_q;
        push      = 1'b0;
        ir_load_o = 1'b0;
        pc_step_o = 1'b0;
        jmp_o     = 1'b0;
        jmpAdrs_o = '0;
        halted_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_load_o = 1'b1;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                pc_step_o = 1'b1;
                state_d   = run_i ? ST_FETCH : ST_IDLE;
                case (br_type_i)
                    BR_JMP: begin
                        jmp_o     = 1'b1;
                        jmpAdrs_o = br_target_i;
                    end
                    BR_JZ: begin
                        jmp_o     = zero_i;
                        jmpAdrs_o = zero_i ? br_target_i : '0;
                    end
                    BR_JNZ: begin
                        jmp_o     = ~zero_i;
                        jmpAdrs_o = zero_i ? '0 : br_target_i;
                    end
                    BR_CALL: begin
                        // A full stack degrades CALL to a sequential advance.
                        if (sp_q != SP_FULL) begin
                            push      = 1'b1;
                            sp_d      = sp_q + SP_W'(1);
                            jmp_o     = 1'b1;
                            jmpAdrs_o = br_target_i;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    BR_RET: begin
                        if (sp_q != '0) begin
                            sp_d      = sp_m1;
                            jmp_o     = 1'b1;
                            jmpAdrs_o = stack_q[sp_m1[IDX_W-1:0]];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    BR_HALT: begin
                        pc_step_o = 1'b0;
                        state_d   = ST_HALTED;
                    end
                    default: ;
                endcase
            end
            ST_HALTED: begin
                halted_o = 1'b1;
                if (!run_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Stack contents need no reset; only entries below sp are ever read.
    always_ff @(posedge clk_i) begin
        if (push) stack_q[sp_q[IDX_W-1:0]] <= ret_addr;
    end

    assign stack_err_o = err_q;
    assign sp_o        = sp_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that sequences the 6-bit program counter datapath: the PC register, its +1 adder and the jump mux.
- Generates the PC advance strobe, jump select and jump address, and the instruction-register load strobe.
- Holds a small return-address stack for CALL/RET.
- Sits between the instruction decoder and the PC; the PC register's clock enable is driven from pc_step instead of being tied high.

Parameters:
- ADDR_W, 6, PC/address width; all address arithmetic is modulo 2^ADDR_W.
- STACK_DEPTH, 4, number of return-address entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = execute, 0 = stop after the current instruction.
- br_type  in  3  decoded op class from the IR: 0 NONE, 1 JMP, 2 JZ, 3 JNZ, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as NONE).
- br_target  in  ADDR_W  branch/call target from the IR.
- zero  in  1  ALU zero flag, sampled in the EXEC cycle.
- pc_in  in  ADDR_W  current PC register value.
- ir_load  out  1  load strobe for the instruction register.
- pc_step  out  1  clock enable for the PC register.
- jmp  out  1  PC mux select; 1 = load jmpAdrs.
- jmpAdrs  out  ADDR_W  jump address into the PC mux.
- halted  out  1  FSM is in HALTED.
- stack_err  out  1  sticky overflow/underflow flag.
- sp  out  clog2(STACK_DEPTH)+1  current stack occupancy, for debug.

Behaviour:

Reset (rst=0, asynchronous):
- State=IDLE; sp=0; stack_err=0; stack contents don't-care.
- All strobes 0; jmpAdrs=0; halted=0.

States:
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: ir_load=1 for exactly 1 cycle. Always go to EXEC next.
- EXEC: exactly 1 cycle.
  - pc_step=1, except for HALT.
  - jmp and jmpAdrs are combinational from br_type, zero and stack state; the PC samples them at the end of this cycle.
  - Next state: FETCH if run=1, else IDLE. HALT goes to HALTED.
- HALTED: halted=1, strobes 0. Go to IDLE when run=0; stays halted while run stays 1.

EXEC decisions:
- NONE/reserved: jmp=0, so the PC takes pc_in+1.
- JMP: jmp=1, jmpAdrs=br_target.
- JZ: jmp=zero.
- JNZ: jmp=~zero.
- For JZ/JNZ, jmpAdrs=br_target whenever jmp=1; when jmp=0, jmpAdrs is don't-care but driven 0.
- CALL, stack not full: push (pc_in+1) mod 2^ADDR_W, sp+=1, jmp=1, jmpAdrs=br_target.
- CALL, stack full (sp==STACK_DEPTH): no push, jmp=0 (sequential advance), stack_err<=1.
- RET, sp>0: jmp=1, jmpAdrs=stack[sp-1], sp-=1.
- RET, sp==0: jmp=0, stack_err<=1.
- HALT: pc_step=0, jmp=0; go to HALTED. The PC keeps pointing at the HALT instruction.

Rules:
- Per-instruction latency is 2 cycles (FETCH+EXEC); the PC updates once per instruction.
- pc_in=2^ADDR_W-1 wraps to 0 for both sequential advance and CALL return address.
- run dropping during FETCH still completes that instruction's EXEC, then goes to IDLE.
- stack_err is cleared only by reset.
- sp saturates at both 0 and STACK_DEPTH and never wraps.
- Reset asserted mid-EXEC aborts the instruction: strobes drop immediately and no stack write is committed.

Test Plan:
- Reset, run=1, br_type=NONE, pc_in 0..3: ir_load/pc_step alternate in 2-cycle cadence; jmp=0 throughout. With pc_in=63, the PC must wrap to 0.
- JZ, br_target=0x2A: with zero=1, jmp=1 and jmpAdrs=0x2A. With zero=0, jmp=0. JNZ must give the inverse.
- CALL target 0x10 at pc_in=0x05, then RET: push 0x06 with sp 0->1 and jmpAdrs=0x10; RET gives jmpAdrs=0x06 with sp 1->0.
- 5 nested CALLs with STACK_DEPTH=4: the fifth gives jmp=0, sp stays 4 and stack_err=1. Then 5 RETs return 4 correct addresses in LIFO order; the fifth gives jmp=0 and sp=0.
- HALT at pc_in=0x0C: pc_step=0 and halted=1, held while run=1. Dropping run goes to IDLE; raising run gives FETCH with ir_load=1.
- rst pulled low during EXEC of a CALL: outputs go to 0 asynchronously, sp=0 and stack_err=0 after release, and the FSM is in IDLE.
